// File: rtl/pc_stack_unit.sv
`default_nettype none
// ==========================================================================
// pc_stack_unit : PC sequencer with operand-byte FSM and circular return stack
// Revision 1.0
// ==========================================================================
module pc_stack_unit #(
  parameter int unsigned         ADDR_W      = 16,
  parameter int unsigned         STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC    = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0]   RST_BASE    = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0]   INT_BASE    = ADDR_W'(16'h0040)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   op_valid,
  input  logic [2:0]                             op,
  input  logic                                   cond_ok,
  input  logic [2:0]                             vec_idx,
  input  logic [ADDR_W-1:0]                      reg_file_in,
  input  logic [7:0]                             data_bus,
  input  logic                                   data_valid,
  output logic [ADDR_W-1:0]                      pc,
  output logic                                   busy,
  output logic [ADDR_W-1:0]                      ret_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       stack_count,
  output logic                                   stack_err
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

  localparam logic [2:0] OP_INCR  = 3'd0;
  localparam logic [2:0] OP_JP    = 3'd1;
  localparam logic [2:0] OP_JR    = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_RST   = 3'd5;
  localparam logic [2:0] OP_INT   = 3'd6;
  localparam logic [2:0] OP_LDREG = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [2:0]          op_q, op_d;
  logic                taken_q, taken_d;
  logic [7:0]          lo_q, lo_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]   stack_d [STACK_DEPTH];
  logic [PTR_W-1:0]    tos_q, tos_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;

  logic                push, pop;
  logic [ADDR_W-1:0]   push_val;
  logic [ADDR_W-1:0]   pc_inc, vec_off, top;
  logic [PTR_W-1:0]    ptr_next, ptr_prev;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign vec_off  = {{(ADDR_W-6){1'b0}}, vec_idx, 3'b000};
  assign top      = stack_q[tos_q];
  assign ptr_next = (tos_q == PTR_W'(STACK_DEPTH-1)) ? '0 : tos_q + PTR_W'(1);
  assign ptr_prev = (tos_q == '0) ? PTR_W'(STACK_DEPTH-1) : tos_q - PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    taken_d  = taken_q;
    lo_d     = lo_q;
    stack_d  = stack_q;
    tos_d    = tos_q;
    count_d  = count_q;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = pc_q;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          unique case (op)
            OP_INCR:  pc_d = pc_inc;
            OP_JP, OP_JR, OP_CALL: begin
              op_d    = op;
              taken_d = cond_ok;
              state_d = WAIT_LO;
            end
            OP_RET: begin
              if (cond_ok) begin
                if (count_q != '0) begin
                  pop  = 1'b1;
                  pc_d = top;
                end else begin
                  err_d = 1'b1;
                end
              end
            end
            OP_RST: begin
              push = 1'b1;
              pc_d = RST_BASE + vec_off;
            end
            OP_INT: begin
              push = 1'b1;
              pc_d = INT_BASE + vec_off;
            end
            OP_LDREG: pc_d = reg_file_in;
            default: ;
          endcase
        end
      end
      WAIT_LO: begin
        if (data_valid) begin
          if (op_q == OP_JR) begin
            pc_d    = taken_q ? pc_inc + {{(ADDR_W-8){data_bus[7]}}, data_bus} : pc_inc;
            state_d = IDLE;
          end else begin
            lo_d    = data_bus;
            pc_d    = pc_inc;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (data_valid) begin
          state_d = IDLE;
          if (taken_q) begin
            pc_d = {{(ADDR_W-16){1'b0}}, data_bus, lo_q};
            if (op_q == OP_CALL) begin
              push     = 1'b1;
              push_val = pc_inc;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A push onto a full stack overwrites the oldest slot as tos wraps onto it.
    if (push) begin
      stack_d[ptr_next] = push_val;
      tos_d             = ptr_next;
      if (count_q == CNT_W'(STACK_DEPTH)) err_d = 1'b1;
      else                                count_d = count_q + CNT_W'(1);
    end else if (pop) begin
      tos_d   = ptr_prev;
      count_d = count_q - CNT_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      op_q    <= OP_INCR;
      taken_q <= 1'b0;
      lo_q    <= 8'h00;
      busy_q  <= 1'b0;
      tos_q   <= PTR_W'(STACK_DEPTH-1);
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      taken_q <= taken_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      tos_q   <= tos_d;
      count_q <= count_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign pc          = pc_q;
  assign busy        = busy_q;
  assign ret_addr    = (count_q == '0) ? '0 : top;
  assign stack_count = count_q;
  assign stack_err   = err_q;

endmodule
`default_nettype wire
